// File: rtl/jp_emu.sv
// -----------------------------------------------------------------------------
// jp_emu -- emulated standard NES controller (device side of the joypad link).
//
// Behaves like the CD4021 shift register inside an official pad: while the
// console holds latch high the register continuously parallel-loads the
// (active-low) button word; after latch falls, every rising edge of the
// console serial clock shifts one bit towards the data pin, with 0 shifted in
// so that a finished read returns "1" to the console for extra bits.
//
// Optional feature macro: JP_TURBO_EN
//   defined   : turbo auto-fire on A/B, phase toggling every TURBO_DIV latches
//   undefined : no turbo logic, turbo_mask ignored, btn_eff = btn_q
//
// Parameters:
//   TURBO_DIV   latch rises per turbo half-period (JP_TURBO_EN only), 1..255
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   jp_clk      in   console serial clock pin, asynchronous to clk
//   jp_latch    in   console latch pin, asynchronous to clk
//   btn_in      in   [7:0] button word, 1 = pressed (A,B,Sel,Start,U,D,L,R)
//   btn_wr      in   one-cycle strobe capturing btn_in
//   turbo_mask  in   [1:0] turbo enable for A (bit 0) and B (bit 1)
//   jp_data     out  serial data pin, active-low (0 = pressed)
//   rd_done     out  one-cycle pulse when the 8th bit has been shifted out
//   poll_cnt    out  [7:0] latch rising-edge counter, wraps
// -----------------------------------------------------------------------------
module jp_emu #(
   parameter int TURBO_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       jp_clk,
   input  logic       jp_latch,
   input  logic [7:0] btn_in,
   input  logic       btn_wr,
   input  logic [1:0] turbo_mask,
   output logic       jp_data,
   output logic       rd_done,
   output logic [7:0] poll_cnt
);

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam logic [7:0] TDIV8 = 8'(TURBO_DIV);

   // Pin synchronisers: meta -> sync, plus a history flop for edge detection
   logic clk_meta_q, clk_sync_q, clk_hist_q;
   logic lat_meta_q, lat_sync_q, lat_hist_q;

   logic clk_rise_s;
   logic lat_rise_s;

   // Core state
   logic [7:0] btn_q;
   logic [7:0] btn_eff_s;
   logic [7:0] sr_q, sr_d;
   logic [3:0] cnt_q, cnt_d;
   state_e     state_q, state_d;
   logic       rd_done_q, rd_done_d;
   logic [7:0] poll_q, poll_d;

   // Two-flop synchronisers and history flops for both console pins
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_meta_q <= 1'b0;
         clk_sync_q <= 1'b0;
         clk_hist_q <= 1'b0;
         lat_meta_q <= 1'b0;
         lat_sync_q <= 1'b0;
         lat_hist_q <= 1'b0;
      end else begin
         clk_meta_q <= jp_clk;
         clk_sync_q <= clk_meta_q;
         clk_hist_q <= clk_sync_q;
         lat_meta_q <= jp_latch;
         lat_sync_q <= lat_meta_q;
         lat_hist_q <= lat_sync_q;
      end
   end

   assign clk_rise_s = clk_sync_q & ~clk_hist_q;
   assign lat_rise_s = lat_sync_q & ~lat_hist_q;

   // Button capture register, sole source for parallel loads
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_q <= 8'h00;
      end else if (btn_wr) begin
         btn_q <= btn_in;
      end else begin
         btn_q <= btn_q;
      end
   end

`ifdef JP_TURBO_EN
   // Turbo phase: tcnt counts latch rises within the current phase; when a
   // rise arrives after TURBO_DIV rises in this phase, the phase flips and
   // that rise becomes the first of the new phase. This makes the flip
   // visible on the very latch that starts the new phase.
   logic [7:0] tcnt_q, tcnt_d;
   logic       turbo_ph_q, turbo_ph_d;

   // Next-state logic for the turbo latch counter and phase
   always_comb begin
      tcnt_d     = tcnt_q;
      turbo_ph_d = turbo_ph_q;
      if (lat_rise_s) begin
         if (tcnt_q >= TDIV8) begin
            tcnt_d     = 8'd1;
            turbo_ph_d = ~turbo_ph_q;
         end else begin
            tcnt_d     = tcnt_q + 8'd1;
            turbo_ph_d = turbo_ph_q;
         end
      end else begin
         tcnt_d     = tcnt_q;
         turbo_ph_d = turbo_ph_q;
      end
   end

   // Turbo counter and phase registers
   always_ff @(posedge clk) begin
      if (rst) begin
         tcnt_q     <= 8'd0;
         turbo_ph_q <= 1'b1;
      end else begin
         tcnt_q     <= tcnt_d;
         turbo_ph_q <= turbo_ph_d;
      end
   end

   // A/B are gated by the turbo phase only where their mask bit is set
   assign btn_eff_s = {btn_q[7:2],
                       btn_q[1] & (turbo_ph_q | ~turbo_mask[1]),
                       btn_q[0] & (turbo_ph_q | ~turbo_mask[0])};
`else
   logic unused_turbo_s;

   assign btn_eff_s      = btn_q;
   assign unused_turbo_s = ^{turbo_mask, TDIV8};
`endif

   // Next-state logic: latch level dominates, otherwise shift on jp_clk rise
   always_comb begin
      sr_d      = sr_q;
      cnt_d     = cnt_q;
      state_d   = state_q;
      rd_done_d = 1'b0;
      poll_d    = poll_q;

      if (lat_rise_s) begin
         poll_d = poll_q + 8'd1;
      end else begin
         poll_d = poll_q;
      end

      if (lat_sync_q) begin
         // Parallel mode: live reload, clock edges ignored (latch wins)
         state_d = ST_LOAD;
         sr_d    = ~btn_eff_s;
         cnt_d   = 4'd0;
      end else begin
         case (state_q)
            ST_LOAD: begin
               // Latch has fallen: freeze the loaded word and start the read
               state_d = ST_SHIFT;
            end
            ST_SHIFT, ST_DONE: begin
               if (clk_rise_s) begin
                  sr_d      = {1'b0, sr_q[7:1]};
                  rd_done_d = (cnt_q == 4'd7);
                  if (cnt_q >= 4'd7) begin
                     cnt_d   = 4'd8;
                     state_d = ST_DONE;
                  end else begin
                     cnt_d   = cnt_q + 4'd1;
                     state_d = ST_SHIFT;
                  end
               end else begin
                  sr_d    = sr_q;
                  cnt_d   = cnt_q;
                  state_d = state_q;
               end
            end
            default: begin
               state_d = ST_SHIFT;
               cnt_d   = 4'd0;
               sr_d    = 8'hFF;
            end
         endcase
      end
   end

   // Core registers: shift register, bit count, state and output pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q      <= 8'hFF;
         cnt_q     <= 4'd0;
         state_q   <= ST_SHIFT;
         rd_done_q <= 1'b0;
         poll_q    <= 8'h00;
      end else begin
         sr_q      <= sr_d;
         cnt_q     <= cnt_d;
         state_q   <= state_d;
         rd_done_q <= rd_done_d;
         poll_q    <= poll_d;
      end
   end

   // Serial pin is the LSB of the active-low shift register
   assign jp_data  = sr_q[0];
   assign rd_done  = rd_done_q;
   assign poll_cnt = poll_q;

endmodule
